// File: rtl/frame_writer_pkg.sv
// Shared types and constants for the frame writer and its counter.
package frame_writer_pkg;

    // Frame writer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } fw_state_e;

    // Smallest address width that can reach (rows-1)*stride + cols-1.
    function automatic int unsigned addr_width_for(input int unsigned rows,
                                                   input int unsigned cols,
                                                   input int unsigned stride);
        int unsigned max_addr;
        max_addr = (rows - 1) * stride + cols - 1;
        return (max_addr < 2) ? 1 : $clog2(max_addr + 1);
    endfunction

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ROWS       = 8;
    localparam int unsigned DEF_COLS       = 8;
    localparam int unsigned DEF_ROW_STRIDE = 8;
    localparam int unsigned DEF_ADDR_WIDTH =
        addr_width_for(DEF_ROWS, DEF_COLS, DEF_ROW_STRIDE);

endpackage

// File: rtl/frame_writer_if.sv
// Control, upstream stream and RAM write bundle of the frame writer.
interface frame_writer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  done;

    // Requester side: issues frames and streams words.
    modport master (
        output start, base_addr, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done
    );

    // Frame writer side.
    modport slave (
        input  start, base_addr, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/wrap_counter2d.sv
// Row/column counter: column wraps into the row, row wraps at the frame end.
module wrap_counter2d #(
    parameter  int unsigned ROWS  = 8,
    parameter  int unsigned COLS  = 8,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_c
);

    logic col_end_c;
    logic row_end_c;

    assign col_end_c = (col == COL_W'(COLS - 1));
    assign row_end_c = (row == ROW_W'(ROWS - 1));
    assign last_c    = col_end_c && row_end_c;

    // Advance one position per enable; clear restarts at the frame origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_end_c) begin
                col <= '0;
                row <= row_end_c ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_writer.sv
// Writes a ROWS x COLS word stream into RAM as a strided 2-D frame.
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned COLS       = DEF_COLS,
    parameter int unsigned ROW_STRIDE = DEF_ROW_STRIDE,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic          CLK,
    input  logic          rst_n,
    frame_writer_if.slave bus
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    fw_state_e             state;
    logic [ADDR_WIDTH-1:0] row_start;
    logic [ROW_W-1:0]      row_unused;
    logic [COL_W-1:0]      col;
    logic                  last_c;
    logic                  xfer_c;
    logic                  clr_c;
    logic                  row_end_c;

    // Accepted word, frame launch and end-of-row decode.
    assign xfer_c    = (state == FILL) && bus.in_valid && bus.in_ready;
    assign clr_c     = (state == IDLE) && bus.start;
    assign row_end_c = (col == COL_W'(COLS - 1));

    // Row index itself is not needed: the running row start carries it.
    wrap_counter2d #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_cnt (
        .clk    (CLK),
        .rst_n  (rst_n),
        .clr    (clr_c),
        .en     (xfer_c),
        .row    (row_unused),
        .col    (col),
        .last_c (last_c)
    );

    // Frame FSM with registered handshake, write port and status outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            row_start    <= '0;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            bus.done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= FILL;
                        row_start    <= bus.base_addr;
                        bus.in_ready <= 1'b1;
                        bus.busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (xfer_c) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= row_start + ADDR_WIDTH'(col);
                        bus.wr_data <= DATA_WIDTH'(bus.in_data);
                        if (row_end_c) begin
                            row_start <= row_start + ADDR_WIDTH'(ROW_STRIDE);
                        end
                        if (last_c) begin
                            state        <= FLUSH;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: strided frame, stalls, ignored start,
// mid-frame reset, address wrap, back-to-back frames and a 1x1 frame.
module tb_frame_writer;

    logic CLK   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    frame_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) ia ();
    frame_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) ib ();
    frame_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) ic ();

    frame_writer #(.DATA_WIDTH(8), .ROWS(2), .COLS(3), .ROW_STRIDE(4), .ADDR_WIDTH(6))
        dut_a (.CLK(CLK), .rst_n(rst_n), .bus(ia));
    frame_writer #(.DATA_WIDTH(8), .ROWS(1), .COLS(4), .ROW_STRIDE(4), .ADDR_WIDTH(6))
        dut_b (.CLK(CLK), .rst_n(rst_n), .bus(ib));
    frame_writer #(.DATA_WIDTH(8), .ROWS(1), .COLS(1), .ROW_STRIDE(1), .ADDR_WIDTH(6))
        dut_c (.CLK(CLK), .rst_n(rst_n), .bus(ic));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, ".in_ready"}, 32'(ia.in_ready), 32'd0);
        chk({tag, ".wr_en"},    32'(ia.wr_en),    32'd0);
        chk({tag, ".wr_addr"},  32'(ia.wr_addr),  32'd0);
        chk({tag, ".wr_data"},  32'(ia.wr_data),  32'd0);
        chk({tag, ".busy"},     32'(ia.busy),     32'd0);
        chk({tag, ".done"},     32'(ia.done),     32'd0);
    endtask

    initial begin
        logic [5:0]  exp_a [6];
        logic [5:0]  exp_b [4];
        logic [15:0] vpat;
        int          k;
        int          nwr;

        exp_a = '{6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14};
        exp_b = '{6'd62, 6'd63, 6'd0, 6'd1};
        vpat  = 16'b0110_1001_1100_1011;

        ia.start = 1'b0; ia.base_addr = '0; ia.in_valid = 1'b0; ia.in_data = '0;
        ib.start = 1'b0; ib.base_addr = '0; ib.in_valid = 1'b0; ib.in_data = '0;
        ic.start = 1'b0; ic.base_addr = '0; ic.in_valid = 1'b0; ic.in_data = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #1 chk_a_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_a_zero("post_reset_idle");

        // Frame 1: 2x3, stride 4, base 8, in_valid held high
        ia.base_addr = 6'd8;
        ia.start     = 1'b1;
        tick();
        chk("f1.in_ready_rise", 32'(ia.in_ready), 32'd1);
        chk("f1.busy_rise",     32'(ia.busy),     32'd1);
        chk("f1.no_write_yet",  32'(ia.wr_en),    32'd0);
        ia.start    = 1'b0;
        ia.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ia.in_data = 8'(8'h10 + i);
            tick();
            chk($sformatf("f1.wr_en[%0d]", i),   32'(ia.wr_en),   32'd1);
            chk($sformatf("f1.wr_addr[%0d]", i), 32'(ia.wr_addr), 32'(exp_a[i]));
            chk($sformatf("f1.wr_data[%0d]", i), 32'(ia.wr_data), 32'(8'h10 + i));
            chk($sformatf("f1.in_ready[%0d]", i), 32'(ia.in_ready), (i < 5) ? 32'd1 : 32'd0);
            chk($sformatf("f1.busy[%0d]", i),    32'(ia.busy),    32'd1);
            chk($sformatf("f1.done[%0d]", i),    32'(ia.done),    32'd0);
        end
        ia.in_valid = 1'b0;
        tick();
        chk("f1.done_pulse", 32'(ia.done),     32'd1);
        chk("f1.done_busy",  32'(ia.busy),     32'd0);
        chk("f1.done_wr_en", 32'(ia.wr_en),    32'd0);
        chk("f1.done_ready", 32'(ia.in_ready), 32'd0);

        // Frame 2 started on the done cycle, with stalls and a stray start
        ia.base_addr = 6'd8;
        ia.start     = 1'b1;
        tick();
        chk("f2.b2b_in_ready", 32'(ia.in_ready), 32'd1);
        chk("f2.b2b_done_low", 32'(ia.done),     32'd0);
        chk("f2.b2b_busy",     32'(ia.busy),     32'd1);
        ia.start = 1'b0;
        k   = 0;
        nwr = 0;
        for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
            ia.in_valid = vpat[cyc % 16];
            ia.in_data  = ia.in_valid ? 8'(8'h40 + k) : 8'hEE;
            ia.start    = (cyc == 3);
            ia.base_addr = (cyc == 3) ? 6'd32 : 6'd8;
            tick();
            if (ia.wr_en) nwr++;
            if (ia.in_valid) begin
                chk($sformatf("f2.wr_en[%0d]", k),   32'(ia.wr_en),   32'd1);
                chk($sformatf("f2.wr_addr[%0d]", k), 32'(ia.wr_addr), 32'(exp_a[k]));
                chk($sformatf("f2.wr_data[%0d]", k), 32'(ia.wr_data), 32'(8'h40 + k));
                k++;
            end else begin
                chk($sformatf("f2.stall_wr_en[c%0d]", cyc), 32'(ia.wr_en), 32'd0);
            end
            chk($sformatf("f2.done_low[c%0d]", cyc), 32'(ia.done), 32'd0);
        end
        ia.start    = 1'b0;
        ia.in_valid = 1'b0;
        chk("f2.words_within_budget", 32'(k), 32'd6);
        tick();
        if (ia.wr_en) nwr++;
        chk("f2.wr_en_count", 32'(nwr),     32'd6);
        chk("f2.done_pulse",  32'(ia.done), 32'd1);
        chk("f2.done_busy",   32'(ia.busy), 32'd0);

        // Frame 3 started on the done cycle, then reset after the 3rd write
        ia.base_addr = 6'd0;
        ia.start     = 1'b1;
        tick();
        chk("f3.b2b_in_ready", 32'(ia.in_ready), 32'd1);
        ia.start    = 1'b0;
        ia.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ia.in_data = 8'(8'h70 + i);
            tick();
            chk($sformatf("f3.wr_addr[%0d]", i), 32'(ia.wr_addr), 32'(i));
            chk($sformatf("f3.wr_data[%0d]", i), 32'(ia.wr_data), 32'(8'h70 + i));
        end
        rst_n = 1'b0;
        #1;
        chk_a_zero("midframe_reset");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_a_zero($sformatf("after_reset[%0d]", i));
        end
        ia.in_valid = 1'b0;

        // Address wrap: 1x4 frame at base 62
        ib.base_addr = 6'd62;
        ib.start     = 1'b1;
        tick();
        chk("wrap.in_ready", 32'(ib.in_ready), 32'd1);
        ib.start    = 1'b0;
        ib.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ib.in_data = 8'(8'h80 + i);
            tick();
            chk($sformatf("wrap.wr_en[%0d]", i),   32'(ib.wr_en),   32'd1);
            chk($sformatf("wrap.wr_addr[%0d]", i), 32'(ib.wr_addr), 32'(exp_b[i]));
            chk($sformatf("wrap.wr_data[%0d]", i), 32'(ib.wr_data), 32'(8'h80 + i));
        end
        ib.in_valid = 1'b0;
        tick();
        chk("wrap.done_pulse", 32'(ib.done), 32'd1);
        chk("wrap.done_busy",  32'(ib.busy), 32'd0);

        // Single-word frame goes straight to FLUSH
        ic.base_addr = 6'd5;
        ic.start     = 1'b1;
        tick();
        chk("one.in_ready", 32'(ic.in_ready), 32'd1);
        ic.start    = 1'b0;
        ic.in_valid = 1'b1;
        ic.in_data  = 8'h5A;
        tick();
        chk("one.wr_en",      32'(ic.wr_en),    32'd1);
        chk("one.wr_addr",    32'(ic.wr_addr),  32'd5);
        chk("one.wr_data",    32'(ic.wr_data),  32'h5A);
        chk("one.flush_rdy",  32'(ic.in_ready), 32'd0);
        chk("one.flush_busy", 32'(ic.busy),     32'd1);
        chk("one.flush_done", 32'(ic.done),     32'd0);
        ic.in_valid = 1'b0;
        tick();
        chk("one.done_pulse", 32'(ic.done),  32'd1);
        chk("one.done_busy",  32'(ic.busy),  32'd0);
        chk("one.done_wr_en", 32'(ic.wr_en), 32'd0);
        tick();
        chk("one.done_clear", 32'(ic.done),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
